// File: rtl/rv32_instruction_encoder.sv
// Encodes structured RV32I instruction requests into 32-bit words streamed to instruction memory.
// Optional macro ENCODER_IMM_CHECK_EN rejects immediates that do not fit their instruction field.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high unless flushing
// ENC   | captured request being encoded and legality-checked
// OUT   | encoded word presented, held until out_ready
module rv32_instruction_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = '1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t      state;
  logic [3:0]  kind_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        imm12_ok, immu_ok, immj_ok;

  assign in_ready = (state == IDLE) && !flush;

`ifdef ENCODER_IMM_CHECK_EN
  always_comb begin
    imm12_ok = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
    immu_ok  = (imm_q[11:0] == '0);
    immj_ok  = ((imm_q[31:20] == '0) || (imm_q[31:20] == '1)) && !imm_q[0];
  end
`else
  always_comb begin
    imm12_ok = 1'b1;
    immu_ok  = 1'b1;
    immj_ok  = 1'b1;
  end
`endif

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (kind_q)
      4'd0: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OP_R};
      4'd1: enc_word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, OP_R};
      4'd2: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b111, rd_q, OP_R};
      4'd3: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b110, rd_q, OP_R};
      4'd4: enc_word = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, OP_R};
      4'd5: begin
        enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OP_IMM};
        enc_legal = imm12_ok;
      end
      4'd6: begin
        enc_word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OP_JALR};
        enc_legal = imm12_ok;
      end
      4'd7: begin
        enc_word  = {imm_q[31:12], rd_q, OP_LUI};
        enc_legal = immu_ok;
      end
      4'd8: begin
        enc_word  = {imm_q[31:12], rd_q, OP_AUIPC};
        enc_legal = immu_ok;
      end
      4'd9: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
        enc_legal = immj_ok;
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // flush outranks every transition and discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kind_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      out_data   <= '0;
      out_addr   <= BASE;
      out_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      word_count <= '0;
    end else if (flush) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      out_addr   <= BASE;
      word_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          kind_q <= in_kind;
          rd_q   <= in_rd;
          rs1_q  <= in_rs1;
          rs2_q  <= in_rs2;
          imm_q  <= in_imm;
          state  <= ENC;
        end
        ENC: begin
          out_data <= enc_word;
          if (enc_legal) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            err_pulse  <= 1'b1;
            err_sticky <= 1'b1;
            state      <= IDLE;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          out_addr  <= out_addr + 1'b1;
          if (word_count != CNT_MAX) word_count <= word_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_instruction_encoder.sv
// Directed bench for rv32_instruction_encoder: vector table plus flush, reset and wrap sequences.
module tb_rv32_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_data;
  logic [7:0]  out_addr;
  logic        err_pulse, err_sticky;
  logic [8:0]  word_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_addr;
  logic [8:0] exp_count;
  logic       exp_sticky;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  rv32_instruction_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_data"}, out_data, 32'd0);
    check({tag, " out_addr"}, 32'(out_addr), 32'd0);
    check({tag, " word_count"}, 32'(word_count), 32'd0);
    check({tag, " err_sticky"}, 32'(err_sticky), 32'd0);
    check({tag, " err_pulse"}, 32'(err_pulse), 32'd0);
  endtask

  // Issue one request from IDLE and follow it through ENC and OUT.
  task automatic do_req(input vec_t v, input int hold);
    @(negedge clk);
    check("in_ready idle", 32'(in_ready), 32'd1);
    in_kind = v.kind; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready enc", 32'(in_ready), 32'd0);
    @(negedge clk);
    if (v.err) begin
      exp_sticky = 1'b1;
      check("err_pulse high", 32'(err_pulse), 32'd1);
      check("no out_valid on err", 32'(out_valid), 32'd0);
      check("err_sticky", 32'(err_sticky), 32'd1);
      @(negedge clk);
      check("err_pulse one cycle", 32'(err_pulse), 32'd0);
      check("addr after err", 32'(out_addr), 32'(exp_addr));
      check("count after err", 32'(word_count), 32'(exp_count));
    end else begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_data", out_data, v.data);
      check("out_addr", 32'(out_addr), 32'(exp_addr));
      check("err_pulse low", 32'(err_pulse), 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold out_valid", 32'(out_valid), 32'd1);
        check("hold out_data", out_data, v.data);
        check("hold in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_addr  = exp_addr + 8'd1;
      exp_count = exp_count + 9'd1;
      check("out_valid after hs", 32'(out_valid), 32'd0);
      check("addr after hs", 32'(out_addr), 32'(exp_addr));
      check("word_count", 32'(word_count), 32'(exp_count));
      check("sticky kept", 32'(err_sticky), 32'(exp_sticky));
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1 check("in_ready under flush", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    exp_addr = '0; exp_count = '0; exp_sticky = 1'b0;
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush err_sticky", 32'(err_sticky), 32'd0);
    check("flush out_addr", 32'(out_addr), 32'd0);
    check("flush word_count", 32'(word_count), 32'd0);
  endtask

  initial begin
    vec_t w;
    vecs[0]  = '{4'd5, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0};
    vecs[1]  = '{4'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0};
    vecs[2]  = '{4'd1, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0};
    vecs[3]  = '{4'd7, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137, 1'b0};
    vecs[4]  = '{4'd9, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0};
    vecs[5]  = '{4'd2, 5'd5, 5'd6, 5'd7, 32'd0,        32'h007372B3, 1'b0};
    vecs[6]  = '{4'd3, 5'd5, 5'd6, 5'd7, 32'd0,        32'h007362B3, 1'b0};
    vecs[7]  = '{4'd4, 5'd5, 5'd6, 5'd7, 32'd0,        32'h007342B3, 1'b0};
    vecs[8]  = '{4'd8, 5'd10, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE517, 1'b0};
    vecs[9]  = '{4'd6, 5'd0, 5'd1, 5'd9, 32'hFFFFFFFC, 32'hFFC08067, 1'b0};
    vecs[10] = '{4'd9, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8, 32'hFF9FF06F, 1'b0};
    vecs[11] = '{4'd15, 5'd1, 5'd1, 5'd1, 32'd0,       32'h0,        1'b1};
    vecs[12] = '{4'd10, 5'd1, 5'd1, 5'd1, 32'd0,       32'h0,        1'b1};
`ifdef ENCODER_IMM_CHECK_EN
    vecs[13] = '{4'd5, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h0,        1'b1};
`else
    vecs[13] = '{4'd5, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b0};
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = '0; exp_count = '0; exp_sticky = 1'b0;
    #12;
    check_reset_vals("reset");
    check("reset in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) do_req(vecs[i], (i == 3) ? 5 : 0);

    do_flush();

    // flush while a word is waiting in OUT drops it
    do_req(vecs[0], 0);
    @(negedge clk);
    in_kind = 4'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("pre-flush out_valid", 32'(out_valid), 32'd1);
    check("pre-flush out_addr", 32'(out_addr), 32'd1);
    do_flush();
    @(negedge clk);
    check("no word after flush", 32'(out_valid), 32'd0);

    // async reset during ENC
    @(negedge clk);
    in_kind = 4'd5; in_imm = 32'd5; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals("rst in ENC");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no word after ENC rst", 32'(out_valid), 32'd0);

    // async reset during OUT
    do_req(vecs[1], 0);
    @(negedge clk);
    in_kind = 4'd1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("pre-rst OUT valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_vals("rst in OUT");
    exp_addr = '0; exp_count = '0; exp_sticky = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no word after OUT rst", 32'(out_valid), 32'd0);

    // 257 words: address wraps 255 -> 0 with no error
    w = vecs[1];
    for (int i = 0; i < 257; i++) do_req(w, 0);
    check("wrap addr", 32'(out_addr), 32'd1);
    check("wrap count", 32'(word_count), 32'd257);
    check("wrap no err", 32'(err_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
